// File: rtl/dz_countdown_matrix_pkg.sv
// Shared types and constants for the countdown matrix timer.
// Digit glyphs live in dz_glyph_rom; this package holds the control-side definitions.
package dz_countdown_matrix_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned Rows     = 8;
  localparam logic [3:0]  MaxDigit = 4'd9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > MaxDigit) ? MaxDigit : d;
  endfunction

endpackage

// File: rtl/dz_countdown_matrix_if.sv
// Control inputs and matrix/status outputs of the countdown timer.
// The controller side uses the master modport; the timer uses the slave modport.
interface dz_countdown_matrix_if;
  logic       start;
  logic       pause;
  logic       load;
  logic [3:0] load_val;
  logic [7:0] row;
  logic [7:0] colr;
  logic [7:0] colg;
  logic [3:0] value;
  logic       done;

  modport master (
    output start, pause, load, load_val,
    input  row, colr, colg, value, done
  );

  modport slave (
    input  start, pause, load, load_val,
    output row, colr, colg, value, done
  );
endinterface

// File: rtl/dz_glyph_rom.sv
// 8x8 digit font: one byte per matrix row, row 0 at the top, bit 7 at the left.
// Digits above 9 render blank.
module dz_glyph_rom (
  input  logic [3:0] digit_i,
  input  logic [2:0] idx_i,
  output logic [7:0] pattern_o
);
  logic [63:0] glyph;
  logic [63:0] glyph_sh;

  always_comb begin
    glyph = 64'h0;
    case (digit_i)
      4'd0:    glyph = 64'h3C66_6666_6666_663C;
      4'd1:    glyph = 64'h1838_1818_1818_183C;
      4'd2:    glyph = 64'h3C66_060C_1830_607E;
      4'd3:    glyph = 64'h3C66_061C_0606_663C;
      4'd4:    glyph = 64'h0C1C_3C6C_7E0C_0C0C;
      4'd5:    glyph = 64'h7E60_607C_0606_663C;
      4'd6:    glyph = 64'h3C66_607C_6666_663C;
      4'd7:    glyph = 64'h7E06_0C18_3030_3030;
      4'd8:    glyph = 64'h3C66_663C_6666_663C;
      4'd9:    glyph = 64'h3C66_663E_0606_663C;
      default: glyph = 64'h0;
    endcase
  end

  // Shift the selected row into the top byte.
  assign glyph_sh  = glyph << {idx_i, 3'b000};
  assign pattern_o = glyph_sh[63:56];
endmodule

// File: rtl/dz_countdown_matrix.sv
// 0-9 countdown timer with start/pause/load control, driving a scanned 8x8 bicolour matrix.
// Row select and column data are registered together from the same scan index.
module dz_countdown_matrix
  import dz_countdown_matrix_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned SCAN_DIV  = 1,
  parameter int unsigned START_VAL = 5,
  parameter int unsigned WARN_VAL  = 2
) (
  input logic                  clk,
  input logic                  rst,
  dz_countdown_matrix_if.slave bus
);
  localparam int unsigned      PresW    = $clog2(TICK_DIV);
  localparam int unsigned      ScanW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned      IdxW     = $clog2(Rows);
  localparam logic [PresW-1:0] PresMax  = PresW'(TICK_DIV - 1);
  localparam logic [ScanW-1:0] ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [3:0]       StartVal = 4'(START_VAL);
  localparam logic [3:0]       WarnVal  = 4'(WARN_VAL);

  state_e           state_q, state_d;
  logic [3:0]       value_q, value_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic             blink_q, blink_d;
  logic [ScanW-1:0] scan_q, scan_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       colr_q, colr_d;
  logic [7:0]       colg_q, colg_d;

  logic             tick;
  logic [PresW-1:0] presc_step;
  logic [7:0]       pattern;
  logic             warn;

  assign tick       = (presc_q == PresMax);
  assign presc_step = tick ? '0 : presc_q + PresW'(1);

  // Load beats everything; within a state start/pause are resolved per state.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    presc_d = presc_q;
    blink_d = blink_q;
    if (bus.load) begin
      state_d = StIdle;
      value_d = clamp_digit(bus.load_val);
      presc_d = '0;
      blink_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            presc_d = '0;
            state_d = (value_q == 4'd0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (bus.pause) begin
            state_d = StPaused;
          end else begin
            presc_d = presc_step;
            if (tick) begin
              if (value_q <= 4'd1) begin
                value_d = 4'd0;
                state_d = StDone;
              end else begin
                value_d = value_q - 4'd1;
              end
            end
          end
        end
        StPaused: begin
          // Prescaler is left untouched so the partial tick survives the pause.
          if (bus.start) state_d = StRun;
        end
        StDone: begin
          if (bus.start) begin
            state_d = StRun;
            value_d = StartVal;
            presc_d = '0;
            blink_d = 1'b0;
          end else begin
            presc_d = presc_step;
            if (tick) blink_d = ~blink_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    scan_d = (scan_q == ScanMax) ? '0 : scan_q + ScanW'(1);
    idx_d  = (scan_q == ScanMax) ? idx_q + IdxW'(1) : idx_q;
  end

  dz_glyph_rom u_glyph_rom (
    .digit_i   (value_q),
    .idx_i     (idx_q),
    .pattern_o (pattern)
  );

  assign warn = (value_q != 4'd0) && (value_q <= WarnVal);

  always_comb begin
    row_d  = ~(8'h01 << idx_q);
    colr_d = '0;
    colg_d = '0;
    if (state_q == StDone) begin
      colr_d = blink_q ? 8'h00 : pattern;
    end else if (warn) begin
      colr_d = pattern;
    end else begin
      colg_d = pattern;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      value_q <= StartVal;
      presc_q <= '0;
      blink_q <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      row_q   <= 8'hFF;
      colr_q  <= 8'h00;
      colg_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      presc_q <= presc_d;
      blink_q <= blink_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      colr_q  <= colr_d;
      colg_q  <= colg_d;
    end
  end

  assign bus.row   = row_q;
  assign bus.colr  = colr_q;
  assign bus.colg  = colg_q;
  assign bus.value = value_q;
  assign bus.done  = (state_q == StDone);
endmodule
